// File: rtl/song_player.sv
// Autoplay sequencer: walks a 15-entry song ROM and drives the piano's one-hot
// switch vector, with a silent gap after every note so repeats stay distinct.
module song_player #(
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 2_500_000,
  parameter int LOOP           = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       play,
  input  logic       stop,
  output logic [7:0] sw_out,
  output logic [3:0] note,
  output logic [3:0] index,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(4 * TICKS_PER_BEAT + GAP_TICKS + 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
  localparam logic [3:0]    LAST_INDEX = 4'd14;

  // Ode to Joy, first phrase; beats stored as (beats-1). Entry 15 is an unused rest.
  localparam logic [3:0] NOTE_ROM [16] = '{
    4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2,
    4'd1, 4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2, 4'd0
  };
  localparam logic [1:0] BEAT_ROM [16] = '{
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0
  };

  typedef enum logic [1:0] {IDLE, NOTE, GAP, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    sw_q;
  logic [3:0]    note_q;
  logic [3:0]    index_q;
  logic          busy_q;
  logic          done_q;

  logic [2:0]    beats_d;
  logic [CW-1:0] note_last_d;
  logic [3:0]    next_index_d;
  logic [3:0]    next_note_d;

  function automatic logic [7:0] decode(input logic [3:0] code);
    decode = 8'h00;
    if (code >= 4'd1 && code <= 4'd8) decode = 8'h80 >> (code - 4'd1);
  endfunction

  always_comb begin
    beats_d      = {1'b0, BEAT_ROM[index_q]} + 3'd1;
    note_last_d  = CW'(int'(beats_d) * TICKS_PER_BEAT - 1);
    next_index_d = (index_q == LAST_INDEX) ? 4'd0 : index_q + 4'd1;
    next_note_d  = NOTE_ROM[next_index_d];
  end

  // stop shares the reset path so an abort never leaves a stale note or done pulse.
  always_ff @(posedge CLK) begin
    if (RESET || stop) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sw_q    <= 8'h00;
      note_q  <= 4'd0;
      index_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            state_q <= NOTE;
            cnt_q   <= '0;
            index_q <= 4'd0;
            note_q  <= NOTE_ROM[0];
            sw_q    <= decode(NOTE_ROM[0]);
            busy_q  <= 1'b1;
          end
        end
        NOTE: begin
          if (cnt_q == note_last_d) begin
            state_q <= GAP;
            cnt_q   <= '0;
            sw_q    <= 8'h00;
            note_q  <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (index_q != LAST_INDEX || LOOP != 0) begin
              state_q <= NOTE;
              index_q <= next_index_d;
              note_q  <= next_note_d;
              sw_q    <= decode(next_note_d);
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          index_q <= 4'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_out = sw_q;
  assign note   = note_q;
  assign index  = index_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player with short beats: one non-looping and one
// looping instance share the same stimulus.
module tb_song_player;

  logic       clk = 1'b0;
  logic       rst, play, stop;
  logic [7:0] sw0, sw1;
  logic [3:0] note0, note1, idx0, idx1;
  logic       busy0, busy1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  // Hand-entered song: beats, note codes and switch patterns per entry.
  int         tb_beats [15] = '{1,1,1,1,1,1,1,1,1,1,1,1,2,1,2};
  logic [3:0] tb_code  [15] = '{3,3,4,5,5,4,3,2,1,1,2,3,3,2,2};
  logic [7:0] tb_sw    [15] = '{8'h20,8'h20,8'h10,8'h08,8'h08,8'h10,8'h20,8'h40,
                                8'h80,8'h80,8'h40,8'h20,8'h20,8'h40,8'h40};

  logic [7:0] sw_log0   [128];
  logic [3:0] note_log0 [128];
  logic [3:0] idx_log0  [128];
  logic       busy_log0 [128];
  logic       done_log0 [128];
  logic [7:0] sw_log1   [128];
  logic [3:0] idx_log1  [128];
  logic       done_log1 [128];

  always #5 clk = ~clk;

  song_player #(.TICKS_PER_BEAT(4), .GAP_TICKS(2), .LOOP(0)) dut0 (
    .CLK(clk), .RESET(rst), .play(play), .stop(stop),
    .sw_out(sw0), .note(note0), .index(idx0), .busy(busy0), .done(done0)
  );

  song_player #(.TICKS_PER_BEAT(4), .GAP_TICKS(2), .LOOP(1)) dut1 (
    .CLK(clk), .RESET(rst), .play(play), .stop(stop),
    .sw_out(sw1), .note(note1), .index(idx1), .busy(busy1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the play edge (k=1 is the first note cycle).
  task automatic model(input int k, input bit loop_en,
                       output logic [7:0] sw, output logic [3:0] nt,
                       output logic [3:0] idx, output logic bz, output logic dn);
    int pos;
    int kk;
    kk  = loop_en ? ((k - 1) % 98) + 1 : k;
    sw  = 8'h00; nt = 4'd0; idx = 4'd0; bz = 1'b0; dn = 1'b0;
    pos = 1;
    for (int i = 0; i < 15; i++) begin
      int nl;
      nl = tb_beats[i] * 4;
      if (kk >= pos && kk < pos + nl) begin
        sw = tb_sw[i]; nt = tb_code[i]; idx = 4'(i); bz = 1'b1;
      end else if (kk >= pos + nl && kk < pos + nl + 2) begin
        idx = 4'(i); bz = 1'b1;
      end
      pos += nl + 2;
    end
    if (!loop_en && kk == pos) begin
      idx = 4'd14; dn = 1'b1;
    end
  endtask

  task automatic check_outputs(input int k, input bit which);
    logic [7:0] esw; logic [3:0] ent, eidx; logic ebz, edn;
    model(k, which, esw, ent, eidx, ebz, edn);
    if (!which) begin
      check_eq($sformatf("d0 k=%0d sw", k), 32'(sw0), 32'(esw));
      check_eq($sformatf("d0 k=%0d note", k), 32'(note0), 32'(ent));
      check_eq($sformatf("d0 k=%0d index", k), 32'(idx0), 32'(eidx));
      check_eq($sformatf("d0 k=%0d busy", k), 32'(busy0), 32'(ebz));
      check_eq($sformatf("d0 k=%0d done", k), 32'(done0), 32'(edn));
    end else begin
      check_eq($sformatf("d1 k=%0d sw", k), 32'(sw1), 32'(esw));
      check_eq($sformatf("d1 k=%0d note", k), 32'(note1), 32'(ent));
      check_eq($sformatf("d1 k=%0d index", k), 32'(idx1), 32'(eidx));
      check_eq($sformatf("d1 k=%0d busy", k), 32'(busy1), 32'(ebz));
      check_eq($sformatf("d1 k=%0d done", k), 32'(done1), 32'(edn));
    end
  endtask

  // Start a song and follow it for last_k cycles; replay_k re-pulses play mid-song.
  task automatic play_song(input int last_k, input int replay_k);
    for (int k = 1; k <= last_k; k++) begin
      play = (k == 1) || (k == replay_k);
      tick();
      play = 1'b0;
      sw_log0[k] = sw0; note_log0[k] = note0; idx_log0[k] = idx0;
      busy_log0[k] = busy0; done_log0[k] = done0;
      sw_log1[k] = sw1; idx_log1[k] = idx1; done_log1[k] = done1;
      check_outputs(k, 1'b0);
      check_outputs(k, 1'b1);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " sw0"}, 32'(sw0), 32'h0);
    check_eq({tag, " note0"}, 32'(note0), 32'h0);
    check_eq({tag, " idx0"}, 32'(idx0), 32'h0);
    check_eq({tag, " busy0"}, 32'(busy0), 32'h0);
    check_eq({tag, " done0"}, 32'(done0), 32'h0);
    check_eq({tag, " sw1"}, 32'(sw1), 32'h0);
    check_eq({tag, " note1"}, 32'(note1), 32'h0);
    check_eq({tag, " idx1"}, 32'(idx1), 32'h0);
    check_eq({tag, " busy1"}, 32'(busy1), 32'h0);
    check_eq({tag, " done1"}, 32'(done1), 32'h0);
  endtask

  initial begin
    int dn_cnt;
    rst = 1'b1; play = 1'b0; stop = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // 1: idle stays silent
    for (int c = 0; c < 20; c++) begin
      tick();
      check_idle($sformatf("idle c=%0d", c));
    end

    // 2/3/6: full song, non-looping and looping side by side
    play_song(105, 0);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("first E sw k=%0d", k), 32'(sw_log0[k]), 32'h20);
      check_eq($sformatf("first E note k=%0d", k), 32'(note_log0[k]), 32'd3);
    end
    check_eq("first gap sw k=5", 32'(sw_log0[5]), 32'h0);
    check_eq("first gap sw k=6", 32'(sw_log0[6]), 32'h0);
    check_eq("second E index", 32'(idx_log0[7]), 32'd1);
    check_eq("second E sw", 32'(sw_log0[7]), 32'h20);
    for (int k = 73; k <= 80; k++)
      check_eq($sformatf("idx12 E k=%0d", k), 32'(sw_log0[k]), 32'h20);
    check_eq("idx12 gap k=81", 32'(sw_log0[81]), 32'h0);
    for (int k = 89; k <= 96; k++)
      check_eq($sformatf("idx14 D k=%0d", k), 32'(sw_log0[k]), 32'h40);
    check_eq("idx14 gap k=97", 32'(sw_log0[97]), 32'h0);
    dn_cnt = 0;
    for (int k = 1; k <= 105; k++) dn_cnt += int'(done_log0[k]);
    check_eq("done pulse count", 32'(dn_cnt), 32'd1);
    check_eq("done at k=99", 32'(done_log0[99]), 32'd1);
    check_eq("busy after done", 32'(busy_log0[100]), 32'd0);
    check_eq("loop wrap index", 32'(idx_log1[99]), 32'd0);
    check_eq("loop wrap sw", 32'(sw_log1[99]), 32'h20);
    check_eq("loop no done", 32'(done_log1[99]), 32'd0);

    // 6b: reset in the middle of a looped note
    check_eq("loop mid-note busy", 32'(busy1), 32'd1);
    check_eq("loop mid-note sw", 32'(sw1), 32'h20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("reset mid-note");

    // 4: stop during index 5
    play_song(32, 0);
    check_eq("before stop index", 32'(idx0), 32'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("after stop");
    dn_cnt = 0;
    for (int c = 0; c < 110; c++) begin
      tick();
      dn_cnt += int'(done0) + int'(busy0);
    end
    check_eq("no done/busy after stop", 32'(dn_cnt), 32'd0);

    // 5: play+stop together, then a stray play during index 3
    play = 1'b1; stop = 1'b1;
    tick();
    play = 1'b0; stop = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_idle($sformatf("play+stop c=%0d", c));
    end
    play_song(105, 20);
    check_eq("replay ignored idx k=20", 32'(idx_log0[20]), 32'd3);
    check_eq("replay ignored idx k=25", 32'(idx_log0[25]), 32'd4);
    check_eq("replay ignored done k=99", 32'(done_log0[99]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
